// File: rtl/packet_match_controller_if.sv
// packet_match_controller_if: MAC/FIFO/comparator/result-memory signals of the packet match controller
interface packet_match_controller_if #(
  parameter int NUM_CMP = 4,
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 16
);
  localparam int ID_W = NUM_CMP > 1 ? $clog2(NUM_CMP) : 1;
  logic               cfg_update_done;
  logic               rx_valid;
  logic               eop;
  logic               rx_error;
  logic               fifo_full;
  logic               fifo_empty;
  logic [NUM_CMP-1:0] match_vec;
  logic               cfg_load;
  logic               fifo_wrreq;
  logic               fifo_rdreq;
  logic               mem_wr;
  logic [ADDR_W-1:0]  mem_addr;
  logic [ID_W-1:0]    match_id;
  logic [CNT_W-1:0]   frames_matched;
  logic [CNT_W-1:0]   frames_dropped;
  logic               busy;
  modport slave (
    input  cfg_update_done, rx_valid, eop, rx_error, fifo_full, fifo_empty, match_vec,
    output cfg_load, fifo_wrreq, fifo_rdreq, mem_wr, mem_addr, match_id,
           frames_matched, frames_dropped, busy
  );
  modport master (
    output cfg_update_done, rx_valid, eop, rx_error, fifo_full, fifo_empty, match_vec,
    input  cfg_load, fifo_wrreq, fifo_rdreq, mem_wr, mem_addr, match_id,
           frames_matched, frames_dropped, busy
  );
endinterface

// File: rtl/packet_match_controller.sv
// packet_match_controller: buffers MAC frames, ORs comparator hits while draining, logs matches and drops
module packet_match_controller #(
  parameter int NUM_CMP   = 4,
  parameter int ADDR_W    = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_WORDS = 384
) (
  input logic clk,
  input logic rst,
  packet_match_controller_if.slave bus
);
  localparam int ID_W = NUM_CMP > 1 ? $clog2(NUM_CMP) : 1;
  localparam int WC_W = $clog2(MAX_WORDS + 1);
  typedef enum logic [2:0] {CFG, IDLE, RECV, COMPARE, STORE, DROP} state_e;
  state_e             state_q, state_d;
  logic [WC_W-1:0]    wcnt_q, wcnt_d;
  logic [NUM_CMP-1:0] sticky_q, sticky_d;
  logic               eop_seen_q, eop_seen_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [ID_W-1:0]    id_q, low_id;
  logic [CNT_W-1:0]   matched_q, dropped_q;
  logic               rx_st, wr, rd, fin, start, over, drop;
  always_comb begin
    low_id = '0;
    for (int i = NUM_CMP - 1; i >= 0; i--) low_id = sticky_q[i] ? ID_W'(i) : low_id;
  end
  always_comb begin
    rx_st      = state_q == IDLE || state_q == RECV;
    wr         = bus.rx_valid && !bus.fifo_full && rx_st;
    rd         = (state_q == COMPARE || state_q == DROP) && !bus.fifo_empty;
    fin        = bus.rx_valid && bus.eop;
    start      = state_q == IDLE && bus.rx_valid;
    wcnt_d     = (start ? '0 : wcnt_q) + WC_W'(wr);
    // A frame that fills the limit on its own eop word is still a complete frame
    over       = wr && wcnt_d == WC_W'(MAX_WORDS) && !fin;
    drop       = bus.rx_error || (bus.rx_valid && bus.fifo_full) || over;
    sticky_d   = start ? '0 : (state_q == COMPARE && rd) ? sticky_q | bus.match_vec : sticky_q;
    eop_seen_d = state_q == DROP ? eop_seen_q || fin : fin;
    state_d    = state_q;
    case (state_q)
      CFG:     state_d = bus.cfg_update_done ? IDLE : CFG;
      IDLE,
      RECV:    state_d = drop ? DROP : fin ? COMPARE : bus.rx_valid ? RECV : state_q;
      COMPARE: state_d = !bus.fifo_empty ? COMPARE : |sticky_q ? STORE : IDLE;
      STORE:   state_d = IDLE;
      DROP:    state_d = bus.fifo_empty && (eop_seen_q || fin) ? IDLE : DROP;
      default: state_d = CFG;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CFG;
      wcnt_q     <= '0;
      sticky_q   <= '0;
      eop_seen_q <= 1'b0;
      addr_q     <= '0;
      id_q       <= '0;
      matched_q  <= '0;
      dropped_q  <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      sticky_q   <= sticky_d;
      eop_seen_q <= eop_seen_d;
      if (state_q == STORE) begin
        addr_q    <= addr_q + ADDR_W'(1);
        id_q      <= low_id;
        matched_q <= matched_q + CNT_W'(matched_q != '1);
      end
      if (state_d == DROP && state_q != DROP) dropped_q <= dropped_q + CNT_W'(dropped_q != '1);
    end
  end
  always_comb begin
    bus.cfg_load       = state_q == CFG;
    bus.fifo_wrreq     = wr;
    bus.fifo_rdreq     = rd;
    bus.mem_wr         = state_q == STORE;
    bus.mem_addr       = addr_q;
    bus.match_id       = state_q == STORE ? low_id : id_q;
    bus.frames_matched = matched_q;
    bus.frames_dropped = dropped_q;
    bus.busy           = state_q != IDLE;
  end
endmodule

// File: tb/tb_packet_match_controller.sv
// tb_packet_match_controller: directed frames against a FIFO occupancy model and hand-derived expectations
module tb_packet_match_controller;
  localparam int NC = 4, AW = 3, CW = 16, MW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_full = 1'b0;
  logic [NC-1:0] match_pat = '0;
  int match_at = 0;
  int occ = 0, rd_num = 0;
  int st_cnt = 0, wr_cnt = 0;
  logic [AW-1:0] st_addr = '0;
  logic [1:0] st_id = '0;
  int n_cmp = 0, n_err = 0;
  int w0;
  always #5 clk = ~clk;
  packet_match_controller_if #(.NUM_CMP(NC), .ADDR_W(AW), .CNT_W(CW)) bus ();
  packet_match_controller #(.NUM_CMP(NC), .ADDR_W(AW), .CNT_W(CW), .MAX_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  assign bus.fifo_empty = occ == 0;
  assign bus.fifo_full  = force_full;
  assign bus.match_vec  = (bus.fifo_rdreq && rd_num == match_at) ? match_pat : '0;
  always @(posedge clk) begin
    occ    <= rst ? 0 : occ + int'(bus.fifo_wrreq) - int'(bus.fifo_rdreq);
    rd_num <= (bus.fifo_wrreq && !bus.busy) ? 0 : rd_num + int'(bus.fifo_rdreq);
  end
  always @(negedge clk) begin
    if (bus.mem_wr) begin
      st_cnt  <= st_cnt + 1;
      st_addr <= bus.mem_addr;
      st_id   <= bus.match_id;
    end
    if (bus.fifo_wrreq) wr_cnt <= wr_cnt + 1;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic send_frame(input int n, input logic [NC-1:0] pat, input int at, input bit with_eop);
    match_pat = pat;
    match_at  = at;
    for (int i = 0; i < n; i++) begin
      bus.rx_valid = 1'b1;
      bus.eop      = with_eop && i == n - 1;
      tick();
    end
    bus.rx_valid = 1'b0;
    bus.eop      = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    int k = 0;
    while (bus.busy === 1'b1 && k < 60) begin
      tick();
      k++;
    end
    chk(tag, int'(k < 60), 1);
    #2;
  endtask
  initial begin
    bus.cfg_update_done = 1'b0;
    bus.rx_valid = 1'b0;
    bus.eop      = 1'b0;
    bus.rx_error = 1'b0;
    tick();
    chk("rst_cfg_load", int'(bus.cfg_load), 1);
    chk("rst_busy", int'(bus.busy), 1);
    chk("rst_mem_addr", int'(bus.mem_addr), 0);
    chk("rst_mem_wr", int'(bus.mem_wr), 0);
    chk("rst_matched", int'(bus.frames_matched), 0);
    chk("rst_match_id", int'(bus.match_id), 0);
    rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk("cfg_load_hold", int'(bus.cfg_load), 1);
      bus.cfg_update_done = c == 3;
    end
    tick();
    bus.cfg_update_done = 1'b0;
    chk("idle_cfg_load", int'(bus.cfg_load), 0);
    chk("idle_busy", int'(bus.busy), 0);
    bus.cfg_update_done = 1'b1;
    tick();
    bus.cfg_update_done = 1'b0;
    chk("cfg_done_ignored", int'(bus.busy), 0);
    // 5-word frame, hits on the second read
    bus.rx_valid = 1'b1;
    #1;
    chk("first_word_wrreq", int'(bus.fifo_wrreq), 1);
    send_frame(5, 4'b0110, 1, 1'b1);
    chk("compare_rdreq", int'(bus.fifo_rdreq), 1);
    wait_idle("f1_idle");
    chk("f1_stores", st_cnt, 1);
    chk("f1_addr", int'(st_addr), 0);
    chk("f1_id", int'(st_id), 1);
    chk("f1_matched", int'(bus.frames_matched), 1);
    chk("f1_mem_addr_after", int'(bus.mem_addr), 1);
    chk("f1_id_held", int'(bus.match_id), 1);
    send_frame(2, 4'b1100, 0, 1'b1);
    wait_idle("f2_idle");
    chk("f2_addr", int'(st_addr), 1);
    chk("f2_id", int'(st_id), 2);
    for (int f = 0; f < 7; f++) begin
      send_frame(2, 4'b1000, 1, 1'b1);
      wait_idle("fn_idle");
    end
    chk("f9_stores", st_cnt, 9);
    chk("f9_addr_wrap", int'(st_addr), 0);
    chk("f9_id", int'(st_id), 3);
    chk("f9_matched", int'(bus.frames_matched), 9);
    chk("f9_mem_addr_after", int'(bus.mem_addr), 1);
    // rx_error together with eop on word 3
    w0 = wr_cnt;
    bus.rx_valid = 1'b1;
    tick();
    tick();
    bus.eop = 1'b1;
    bus.rx_error = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    bus.eop = 1'b0;
    bus.rx_error = 1'b0;
    #1;
    chk("err_in_drop", int'(bus.busy), 1);
    chk("err_no_mem_wr", int'(bus.mem_wr), 0);
    wait_idle("err_idle");
    chk("err_flushed", occ, 0);
    chk("err_writes", wr_cnt - w0, 3);
    chk("err_dropped", int'(bus.frames_dropped), 1);
    chk("err_no_store", st_cnt, 9);
    chk("err_id_held", int'(bus.match_id), 3);
    // over-length frame: dropped after the 8th write, then waits for eop
    w0 = wr_cnt;
    send_frame(10, '0, 0, 1'b0);
    chk("long_writes", wr_cnt - w0, 8);
    repeat (12) tick();
    chk("long_waits_eop", int'(bus.busy), 1);
    chk("long_flushed", occ, 0);
    chk("long_dropped", int'(bus.frames_dropped), 2);
    bus.rx_valid = 1'b1;
    bus.eop = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    bus.eop = 1'b0;
    #1;
    chk("long_idle_after_eop", int'(bus.busy), 0);
    send_frame(3, '0, 0, 1'b1);
    wait_idle("nomatch_idle");
    chk("nomatch_no_store", st_cnt, 9);
    chk("nomatch_matched", int'(bus.frames_matched), 9);
    chk("nomatch_dropped", int'(bus.frames_dropped), 2);
    // FIFO full on the eop word
    bus.rx_valid = 1'b1;
    tick();
    force_full = 1'b1;
    bus.eop = 1'b1;
    #1;
    chk("full_no_wrreq", int'(bus.fifo_wrreq), 0);
    tick();
    force_full = 1'b0;
    bus.rx_valid = 1'b0;
    bus.eop = 1'b0;
    wait_idle("full_idle");
    chk("full_dropped", int'(bus.frames_dropped), 3);
    chk("full_flushed", occ, 0);
    // reset mid-frame
    bus.rx_valid = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    #1;
    chk("mrst_cfg_load", int'(bus.cfg_load), 1);
    chk("mrst_busy", int'(bus.busy), 1);
    chk("mrst_dropped", int'(bus.frames_dropped), 0);
    chk("mrst_matched", int'(bus.frames_matched), 0);
    chk("mrst_mem_addr", int'(bus.mem_addr), 0);
    chk("mrst_match_id", int'(bus.match_id), 0);
    chk("mrst_wrreq", int'(bus.fifo_wrreq), 0);
    bus.cfg_update_done = 1'b1;
    tick();
    bus.cfg_update_done = 1'b0;
    #1;
    chk("mrst_idle", int'(bus.busy), 0);
    send_frame(2, 4'b0001, 0, 1'b1);
    wait_idle("post_rst_idle");
    chk("post_rst_addr", int'(st_addr), 0);
    chk("post_rst_id", int'(st_id), 0);
    chk("post_rst_matched", int'(bus.frames_matched), 1);
    chk("post_rst_dropped", int'(bus.frames_dropped), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
